// File: rtl/cp0_reg_if.sv
// Signal bundle between the MEM-stage exception logic and the CP0 register file.
// The CP0 block is the slave; the pipeline side (or a bench) is the master.
interface cp0_reg_if #(
  parameter int EXCEPT_W = 32
);
  logic                we_i;
  logic [4:0]          waddr_i;
  logic [4:0]          raddr_i;
  logic [31:0]         data_i;
  logic [5:0]          int_i;
  logic [EXCEPT_W-1:0] except_type_i;
  logic [31:0]         pc_i;
  logic                is_in_delayslot_i;
  logic [31:0]         badvaddr_i;
  logic [31:0]         data_o;
  logic [31:0]         count_o;
  logic [31:0]         compare_o;
  logic [31:0]         status_o;
  logic [31:0]         cause_o;
  logic [31:0]         epc_o;
  logic [31:0]         badvaddr_o;
  logic                timer_int_o;

  modport slave (
    input  we_i, waddr_i, raddr_i, data_i, int_i, except_type_i,
           pc_i, is_in_delayslot_i, badvaddr_i,
    output data_o, count_o, compare_o, status_o, cause_o, epc_o,
           badvaddr_o, timer_int_o
  );

  modport master (
    output we_i, waddr_i, raddr_i, data_i, int_i, except_type_i,
           pc_i, is_in_delayslot_i, badvaddr_i,
    input  data_o, count_o, compare_o, status_o, cause_o, epc_o,
           badvaddr_o, timer_int_o
  );
endinterface

// File: rtl/cp0_reg.sv
// MIPS coprocessor-0 register file: Status/Cause/EPC/BadVAddr, Count/Compare timer,
// mtc0/mfc0 access and exception/ERET commit from the MEM stage.
module cp0_reg #(
  parameter int EXCEPT_W = 32
) (
  input  logic          clk,
  input  logic          rst,
  cp0_reg_if.slave      bus
);

  localparam logic [4:0] REG_BADVADDR = 5'd8;
  localparam logic [4:0] REG_COUNT    = 5'd9;
  localparam logic [4:0] REG_COMPARE  = 5'd11;
  localparam logic [4:0] REG_STATUS   = 5'd12;
  localparam logic [4:0] REG_CAUSE    = 5'd13;
  localparam logic [4:0] REG_EPC      = 5'd14;

  localparam logic [EXCEPT_W-1:0] EXC_INT  = EXCEPT_W'(32'h1);
  localparam logic [EXCEPT_W-1:0] EXC_ADEL = EXCEPT_W'(32'h4);
  localparam logic [EXCEPT_W-1:0] EXC_ADES = EXCEPT_W'(32'h5);
  localparam logic [EXCEPT_W-1:0] EXC_SYS  = EXCEPT_W'(32'h8);
  localparam logic [EXCEPT_W-1:0] EXC_BP   = EXCEPT_W'(32'h9);
  localparam logic [EXCEPT_W-1:0] EXC_RI   = EXCEPT_W'(32'ha);
  localparam logic [EXCEPT_W-1:0] EXC_OV   = EXCEPT_W'(32'hc);
  localparam logic [EXCEPT_W-1:0] EXC_ERET = EXCEPT_W'(32'he);

  localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;
  localparam logic [31:0] STATUS_FIXED = 32'h0040_0000;
  localparam logic [31:0] STATUS_EXL   = 32'h0000_0002;

  logic [31:0] count_r, compare_r, status_r, cause_r, epc_r, badvaddr_r;
  logic        tick_r, timer_int_r;

  logic [31:0] count_nxt_s, compare_nxt_s, status_nxt_s, cause_nxt_s, epc_nxt_s, badvaddr_nxt_s;
  logic        timer_int_nxt_s;
  logic        exc_valid_s, eret_s, addr_exc_s;
  logic [4:0]  exc_code_s;
  logic        wr_count_s, wr_compare_s, wr_status_s, wr_cause_s, wr_epc_s;
  logic [31:0] rdata_s;

  assign wr_count_s   = bus.we_i && (bus.waddr_i == REG_COUNT);
  assign wr_compare_s = bus.we_i && (bus.waddr_i == REG_COMPARE);
  assign wr_status_s  = bus.we_i && (bus.waddr_i == REG_STATUS);
  assign wr_cause_s   = bus.we_i && (bus.waddr_i == REG_CAUSE);
  assign wr_epc_s     = bus.we_i && (bus.waddr_i == REG_EPC);

  // Decode the resolved exception type; unknown codes behave as no exception.
  always_comb begin
    exc_valid_s = 1'b0;
    eret_s      = 1'b0;
    addr_exc_s  = 1'b0;
    exc_code_s  = 5'h00;
    case (bus.except_type_i)
      EXC_INT:  begin exc_valid_s = 1'b1; exc_code_s = 5'h00; end
      EXC_ADEL: begin exc_valid_s = 1'b1; exc_code_s = 5'h04; addr_exc_s = 1'b1; end
      EXC_ADES: begin exc_valid_s = 1'b1; exc_code_s = 5'h05; addr_exc_s = 1'b1; end
      EXC_SYS:  begin exc_valid_s = 1'b1; exc_code_s = 5'h08; end
      EXC_BP:   begin exc_valid_s = 1'b1; exc_code_s = 5'h09; end
      EXC_RI:   begin exc_valid_s = 1'b1; exc_code_s = 5'h0a; end
      EXC_OV:   begin exc_valid_s = 1'b1; exc_code_s = 5'h0c; end
      EXC_ERET: begin eret_s = 1'b1; end
      default:  begin exc_valid_s = 1'b0; eret_s = 1'b0; end
    endcase
  end

  // Next-state for timer, Count and Compare; mtc0 to these is never blocked by an exception.
  always_comb begin
    count_nxt_s     = count_r;
    compare_nxt_s   = compare_r;
    timer_int_nxt_s = timer_int_r;
    if (wr_count_s) begin
      count_nxt_s = bus.data_i;
    end else if (tick_r) begin
      count_nxt_s = count_r + 32'd1;
    end else begin
      count_nxt_s = count_r;
    end
    if (wr_compare_s) begin
      compare_nxt_s = bus.data_i;
    end else begin
      compare_nxt_s = compare_r;
    end
    // Writing Compare acknowledges the timer and takes priority over a coincident match.
    if (wr_compare_s) begin
      timer_int_nxt_s = 1'b0;
    end else if ((compare_r != 32'd0) && (count_r == compare_r)) begin
      timer_int_nxt_s = 1'b1;
    end else begin
      timer_int_nxt_s = timer_int_r;
    end
  end

  // Next-state for Status/Cause/EPC/BadVAddr; exception and ERET pre-empt mtc0 here.
  always_comb begin
    status_nxt_s   = status_r;
    cause_nxt_s    = cause_r;
    epc_nxt_s      = epc_r;
    badvaddr_nxt_s = badvaddr_r;

    cause_nxt_s[15:10] = {bus.int_i[5] | timer_int_r, bus.int_i[4:0]};
    cause_nxt_s[30]    = timer_int_r;

    if (exc_valid_s) begin
      status_nxt_s     = status_r | STATUS_EXL;
      cause_nxt_s[6:2] = exc_code_s;
      if (!status_r[1]) begin
        epc_nxt_s       = bus.is_in_delayslot_i ? (bus.pc_i - 32'd4) : bus.pc_i;
        cause_nxt_s[31] = bus.is_in_delayslot_i;
      end else begin
        epc_nxt_s       = epc_r;
        cause_nxt_s[31] = cause_r[31];
      end
      if (addr_exc_s) begin
        badvaddr_nxt_s = bus.badvaddr_i;
      end else begin
        badvaddr_nxt_s = badvaddr_r;
      end
    end else if (eret_s) begin
      status_nxt_s = status_r & ~STATUS_EXL;
    end else begin
      if (wr_status_s) begin
        status_nxt_s = (bus.data_i & STATUS_WMASK) | STATUS_FIXED;
      end else begin
        status_nxt_s = status_r;
      end
      if (wr_cause_s) begin
        cause_nxt_s[9:8] = bus.data_i[9:8];
      end else begin
        cause_nxt_s[9:8] = cause_r[9:8];
      end
      if (wr_epc_s) begin
        epc_nxt_s = bus.data_i;
      end else begin
        epc_nxt_s = epc_r;
      end
    end
  end

  // Register update with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_r     <= 32'h0000_0000;
      compare_r   <= 32'h0000_0000;
      status_r    <= STATUS_FIXED;
      cause_r     <= 32'h0000_0000;
      epc_r       <= 32'h0000_0000;
      badvaddr_r  <= 32'h0000_0000;
      tick_r      <= 1'b0;
      timer_int_r <= 1'b0;
    end else begin
      count_r     <= count_nxt_s;
      compare_r   <= compare_nxt_s;
      status_r    <= status_nxt_s;
      cause_r     <= cause_nxt_s;
      epc_r       <= epc_nxt_s;
      badvaddr_r  <= badvaddr_nxt_s;
      tick_r      <= ~tick_r;
      timer_int_r <= timer_int_nxt_s;
    end
  end

  // mfc0 read mux; a same-cycle mtc0 is deliberately not bypassed.
  always_comb begin
    rdata_s = 32'h0000_0000;
    case (bus.raddr_i)
      REG_BADVADDR: rdata_s = badvaddr_r;
      REG_COUNT:    rdata_s = count_r;
      REG_COMPARE:  rdata_s = compare_r;
      REG_STATUS:   rdata_s = status_r;
      REG_CAUSE:    rdata_s = cause_r;
      REG_EPC:      rdata_s = epc_r;
      default:      rdata_s = 32'h0000_0000;
    endcase
  end

  assign bus.data_o      = rdata_s;
  assign bus.count_o     = count_r;
  assign bus.compare_o   = compare_r;
  assign bus.status_o    = status_r;
  assign bus.cause_o     = cause_r;
  assign bus.epc_o       = epc_r;
  assign bus.badvaddr_o  = badvaddr_r;
  assign bus.timer_int_o = timer_int_r;

endmodule

// File: tb/tb_cp0_reg.sv
// Bench for cp0_reg: directed scenarios then random traffic, all checked against
// a register-level reference model of the CP0 rules.
module tb_cp0_reg;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  cp0_reg_if #(.EXCEPT_W(32)) bus ();
  cp0_reg #(.EXCEPT_W(32)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_assert = 0;
  int n_fail   = 0;

  logic [31:0] m_count, m_compare, m_status, m_cause, m_epc, m_bad;
  logic        m_tick, m_ti;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_count = 32'd0; m_compare = 32'd0; m_status = 32'h0040_0000;
    m_cause = 32'd0; m_epc = 32'd0; m_bad = 32'd0; m_tick = 1'b0; m_ti = 1'b0;
  endtask

  function automatic logic [31:0] model_read(input logic [4:0] a);
    case (a)
      5'd8:    return m_bad;
      5'd9:    return m_count;
      5'd11:   return m_compare;
      5'd12:   return m_status;
      5'd13:   return m_cause;
      5'd14:   return m_epc;
      default: return 32'd0;
    endcase
  endfunction

  task automatic check_all();
    logic [4:0] ra;
    chk("count", bus.count_o, m_count);
    chk("compare", bus.compare_o, m_compare);
    chk("status", bus.status_o, m_status);
    chk("cause", bus.cause_o, m_cause);
    chk("epc", bus.epc_o, m_epc);
    chk("badvaddr", bus.badvaddr_o, m_bad);
    chk("timer_int", {31'd0, bus.timer_int_o}, {31'd0, m_ti});
    ra = 5'($urandom_range(0, 31));
    if (($urandom & 32'd1) == 32'd1) ra = 5'($urandom_range(8, 14));
    bus.raddr_i = ra;
    #1;
    chk("data_o", bus.data_o, model_read(ra));
  endtask

  // One clock: evaluate the rules on the current inputs, let the edge pass, compare.
  task automatic cycle();
    logic [31:0] t, n_count, n_compare, n_status, n_cause, n_epc, n_bad;
    logic        n_ti, exc, eret;
    t    = bus.except_type_i;
    exc  = t inside {32'h1, 32'h4, 32'h5, 32'h8, 32'h9, 32'ha, 32'hc};
    eret = (t == 32'he);
    n_count   = (bus.we_i && bus.waddr_i == 5'd9) ? bus.data_i : m_count + (m_tick ? 32'd1 : 32'd0);
    n_compare = (bus.we_i && bus.waddr_i == 5'd11) ? bus.data_i : m_compare;
    if (bus.we_i && bus.waddr_i == 5'd11) n_ti = 1'b0;
    else n_ti = m_ti | ((m_compare != 32'd0) && (m_count == m_compare));
    n_status = m_status; n_cause = m_cause; n_epc = m_epc; n_bad = m_bad;
    n_cause[15:10] = {bus.int_i[5] | m_ti, bus.int_i[4:0]};
    n_cause[30]    = m_ti;
    if (exc) begin
      if (m_status[1] == 1'b0) begin
        n_epc = bus.is_in_delayslot_i ? bus.pc_i - 32'd4 : bus.pc_i;
        n_cause[31] = bus.is_in_delayslot_i;
      end
      n_status[1] = 1'b1;
      n_cause[6:2] = (t == 32'h1) ? 5'd0 : t[4:0];
      if (t == 32'h4 || t == 32'h5) n_bad = bus.badvaddr_i;
    end else if (eret) begin
      n_status[1] = 1'b0;
    end else if (bus.we_i) begin
      if (bus.waddr_i == 5'd12) n_status = (bus.data_i & 32'h0000_FF03) | 32'h0040_0000;
      if (bus.waddr_i == 5'd13) n_cause[9:8] = bus.data_i[9:8];
      if (bus.waddr_i == 5'd14) n_epc = bus.data_i;
    end
    @(posedge clk);
    #1;
    m_count = n_count; m_compare = n_compare; m_ti = n_ti; m_tick = ~m_tick;
    m_status = n_status; m_cause = n_cause; m_epc = n_epc; m_bad = n_bad;
    check_all();
  endtask

  task automatic idle_inputs();
    bus.we_i = 1'b0; bus.waddr_i = 5'd0; bus.data_i = 32'd0; bus.int_i = 6'd0;
    bus.except_type_i = 32'd0; bus.pc_i = 32'd0; bus.is_in_delayslot_i = 1'b0;
    bus.badvaddr_i = 32'd0;
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    bus.we_i = 1'b1; bus.waddr_i = a; bus.data_i = d;
    cycle();
    bus.we_i = 1'b0;
  endtask

  task automatic take_exc(input logic [31:0] t, input logic [31:0] pc, input logic ds, input logic [31:0] bad);
    bus.except_type_i = t; bus.pc_i = pc; bus.is_in_delayslot_i = ds; bus.badvaddr_i = bad;
    cycle();
    bus.except_type_i = 32'd0; bus.is_in_delayslot_i = 1'b0;
  endtask

  initial begin
    logic [31:0] types [10];
    logic [4:0]  addrs [7];
    types = '{32'h1, 32'h4, 32'h5, 32'h8, 32'h9, 32'ha, 32'hc, 32'he, 32'h3, 32'h7};
    addrs = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd0};
    idle_inputs();
    bus.raddr_i = 5'd0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_all();
    chk("rst_status", bus.status_o, 32'h0040_0000);
    chk("rst_cause", bus.cause_o, 32'd0);
    rst = 1'b1;
    repeat (10) cycle();
    chk("count_after_10", bus.count_o, 32'd5);

    // Timer match, then acknowledge by rewriting Compare.
    mtc0(5'd9, 32'h10);
    mtc0(5'd11, 32'h14);
    repeat (12) cycle();
    chk("timer_set", {31'd0, bus.timer_int_o}, 32'd1);
    chk("cause_ti", {31'd0, bus.cause_o[30]}, 32'd1);
    chk("cause_ip7", {31'd0, bus.cause_o[15]}, 32'd1);
    mtc0(5'd11, 32'h100);
    chk("timer_clr", {31'd0, bus.timer_int_o}, 32'd0);

    take_exc(32'h8, 32'hBFC0_1004, 1'b1, 32'd0);
    chk("sys_epc", bus.epc_o, 32'hBFC0_1000);
    chk("sys_bd", {31'd0, bus.cause_o[31]}, 32'd1);
    chk("sys_code", {27'd0, bus.cause_o[6:2]}, 32'h08);
    chk("sys_exl", {31'd0, bus.status_o[1]}, 32'd1);
    take_exc(32'he, 32'd0, 1'b0, 32'd0);

    take_exc(32'h4, 32'h8000_0010, 1'b0, 32'h8000_0013);
    chk("adel_bad", bus.badvaddr_o, 32'h8000_0013);
    chk("adel_code", {27'd0, bus.cause_o[6:2]}, 32'h04);
    take_exc(32'he, 32'd0, 1'b0, 32'd0);
    chk("eret_exl", {31'd0, bus.status_o[1]}, 32'd0);
    chk("eret_epc", bus.epc_o, 32'h8000_0010);

    take_exc(32'h8, 32'h500, 1'b0, 32'd0);
    take_exc(32'hc, 32'h1234, 1'b0, 32'd0);
    chk("nest_epc", bus.epc_o, 32'h500);
    chk("nest_code", {27'd0, bus.cause_o[6:2]}, 32'h0c);
    take_exc(32'he, 32'd0, 1'b0, 32'd0);

    bus.we_i = 1'b1; bus.waddr_i = 5'd14; bus.data_i = 32'hDEAD_BEEF;
    take_exc(32'ha, 32'h40, 1'b0, 32'd0);
    bus.we_i = 1'b0;
    chk("coll_epc", bus.epc_o, 32'h40);
    take_exc(32'he, 32'd0, 1'b0, 32'd0);
    mtc0(5'd12, 32'hFFFF_FFFF);
    chk("status_mask", bus.status_o, 32'h0040_FF03);

    // Random traffic with an asynchronous reset pulse halfway.
    for (int i = 0; i < 400; i++) begin
      if (i == 200) begin
        rst = 1'b0;
        #2;
        model_reset();
        check_all();
        @(posedge clk);
        #1;
        rst = 1'b1;
        check_all();
      end
      bus.we_i = (($urandom % 3) == 0);
      bus.waddr_i = addrs[$urandom_range(0, 6)];
      if (bus.waddr_i == 5'd0) bus.waddr_i = 5'($urandom_range(0, 31));
      bus.data_i = $urandom;
      if (bus.waddr_i == 5'd11 && ($urandom % 2) == 0) bus.data_i = m_count + 32'($urandom_range(0, 8));
      bus.int_i = 6'($urandom_range(0, 63));
      bus.except_type_i = (($urandom % 16) < 9) ? 32'd0 : types[$urandom_range(0, 9)];
      bus.pc_i = $urandom;
      bus.is_in_delayslot_i = 1'($urandom_range(0, 1));
      bus.badvaddr_i = $urandom;
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/cp0_reg.md
Name: cp0_reg

Overview:
- Coprocessor-0 register file for the MIPS pipeline.
- Sits beside the MEM stage and supplies Status/Cause/EPC to the exception-decision logic.
- Consumes the resolved exception type, faulting PC and bad address back from that logic.
- Services mtc0 writes and mfc0 reads, runs the Count/Compare timer, and samples hardware interrupt lines into Cause.IP.

Parameters:
- EXCEPT_W, 32, width of except_type_i; encodings from defines.vh: NOEXC 0x0, INT 0x1, ADEL 0x4, ADES 0x5, SYS 0x8, BP 0x9, RI 0xa, OV 0xc, ERET 0xe.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-low.
- we_i  input  1  mtc0 write enable.
- waddr_i  input  5  mtc0 destination register number.
- raddr_i  input  5  mfc0 source register number.
- data_i  input  32  mtc0 write data.
- int_i  input  6  hardware interrupt lines HW5..HW0, level-sensitive.
- except_type_i  input  32  resolved exception type from MEM stage.
- pc_i  input  32  PC of the MEM-stage instruction.
- is_in_delayslot_i  input  1  MEM instruction is in a branch delay slot.
- badvaddr_i  input  32  faulting address for AdEL/AdES.
- data_o  output  32  mfc0 read data.
- count_o  output  32  Count (reg 9).
- compare_o  output  32  Compare (reg 11).
- status_o  output  32  Status (reg 12).
- cause_o  output  32  Cause (reg 13).
- epc_o  output  32  EPC (reg 14).
- badvaddr_o  output  32  BadVAddr (reg 8).
- timer_int_o  output  1  timer interrupt pending.

Behaviour:
- Reset (rst low, async): Status=0x0040_0000 (BEV=1), all other registers 0, internal tick=0, timer_int_o=0.
- All outputs are registered values.
- data_o is combinational on raddr_i: 8, 9, 11, 12, 13 or 14 select the matching register; any other address reads 0.
- No write-to-read bypass; a same-cycle mtc0 is not visible on data_o until the next cycle.
- Count tick:
  - tick toggles every cycle.
  - Count increments by 1 on cycles where tick==1, i.e. half the clk rate, with wrap 0xFFFF_FFFF->0.
  - An mtc0 to Count overrides the increment that cycle.
- Timer:
  - timer_int_o sets when Compare!=0 and Count==Compare, and stays set.
  - Any mtc0 to Compare clears timer_int_o that cycle; clear wins over a same-cycle match.
- Cause interrupt bits, sampled every cycle:
  - Cause[15:10] (IP7..IP2) <= {int_i[5]|timer_int_o, int_i[4:0]}.
  - Cause[30] (TI) <= timer_int_o.
- mtc0 write masks (unlisted bits are read-only):
  - Status: writable bits 15:8 (IM), 1 (EXL), 0 (IE); bit 22 always reads 1; all other bits read 0.
  - Cause: writable bits 9:8 (IP1..0, software interrupts) only.
  - EPC, Count, Compare: fully writable.
  - BadVAddr: not writable.
- Exception commit, when except_type_i is neither NOEXC nor ERET:
  - If Status.EXL==0: EPC <= is_in_delayslot_i ? pc_i-4 : pc_i, and Cause[31] (BD) <= is_in_delayslot_i.
  - If Status.EXL==1: EPC and BD are unchanged.
  - Always: Status.EXL <= 1, and Cause[6:2] (ExcCode) <= 0x00 / 0x04 / 0x05 / 0x08 / 0x09 / 0x0a / 0x0c for INT / ADEL / ADES / SYS / BP / RI / OV.
  - ADEL or ADES additionally loads BadVAddr <= badvaddr_i.
  - An unrecognised non-zero type is treated as no exception.
- ERET: Status.EXL <= 0; nothing else changes.
- Simultaneous exception/ERET and mtc0:
  - The exception/ERET update of Status, Cause, EPC and BadVAddr wins; the mtc0 write to those registers is dropped.
  - mtc0 to Count or Compare still takes effect.
- Asserting rst mid-operation returns every register to its reset value immediately, independent of clk.

Test Plan:
- Reset: hold rst low 3 cycles -> status_o=0x0040_0000, cause_o=0, epc_o=0, count_o=0, timer_int_o=0; after release count_o reaches 5 after 10 cycles.
- Timer: mtc0 Count=0x10, then Compare=0x14 -> timer_int_o=1 and cause_o[30]=1, cause_o[15]=1 after 8 cycles; mtc0 Compare=0x100 -> timer_int_o=0 next cycle.
- Syscall in delay slot, EXL=0, pc_i=0xBFC0_1004 -> epc_o=0xBFC0_1000, cause_o[31]=1, ExcCode=0x08, status_o[1]=1.
- AdEL, pc_i=0x8000_0010, badvaddr_i=0x8000_0013 -> badvaddr_o=0x8000_0013, ExcCode=0x04; then ERET -> status_o[1]=0, epc_o unchanged.
- Nested: with EXL=1 apply OV, pc_i=0x1234 -> epc_o retains prior value, ExcCode=0x0c.
- Collision: same cycle mtc0 EPC=0xDEAD_BEEF plus RI at pc_i=0x40 -> epc_o=0x40; mtc0 Status=0xFFFF_FFFF alone -> status_o=0x0040_FF03.
